// File: rtl/cart_mem_arbiter_pkg.sv
// Shared types and constants for the cart memory arbiter slice.
package cart_mem_pkg;

  // Arbiter sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  // Requester identity, used to route a completion back to its owner.
  typedef enum logic [1:0] {
    P_DL  = 2'd0,
    P_DMA = 2'd1,
    P_CPU = 2'd2
  } port_id_t;

  // Byte returned when the cart bus floats (aborted read, power-up).
  localparam logic [7:0] OPEN_BUS_BYTE = 8'hFF;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Requester and SDRAM-side signals of the cart memory arbiter.
// The arbiter itself uses the slave view; the surrounding system uses master.
interface cart_mem_arbiter_if #(
  parameter int ADDR_W = 25
) ();

  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_ack;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_data;
  logic              dma_valid;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              cpu_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  logic              timeout_err;

  modport slave (
    input  dl_req, dl_addr, dl_data,
    input  dma_req, dma_addr,
    input  cpu_req, cpu_addr,
    input  mem_ack, mem_rdata,
    output dl_ack,
    output dma_data, dma_valid,
    output cpu_data, cpu_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output timeout_err
  );

  modport master (
    output dl_req, dl_addr, dl_data,
    output dma_req, dma_addr,
    output cpu_req, cpu_addr,
    output mem_ack, mem_rdata,
    input  dl_ack,
    input  dma_data, dma_valid,
    input  cpu_data, cpu_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  timeout_err
  );

endinterface

// File: rtl/cart_mem_port.sv
// One read requester: pending flag, latched address, one-entry hit
// register and the byte returned to the requester.
module cart_mem_port
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_done,
  input  logic              i_done_ok,
  input  logic [ADDR_W-1:0] i_done_addr,
  input  logic [7:0]        i_done_data,
  input  logic              i_wr_done,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data,
  output logic              o_valid
);

  logic              r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hit_valid;
  logic [ADDR_W-1:0] r_hit_addr;
  logic              r_hit_pend;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              w_hit;

  // A request that is already queued is merged, never short-circuited, so a
  // port can only ever produce one completion per outstanding request.
  assign w_hit = i_req && !r_pending && r_hit_valid && (i_addr == r_hit_addr);

  // Request capture, hit short-cut, completion and write-coherence updates.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_addr      <= '0;
      r_hit_valid <= 1'b0;
      r_hit_addr  <= '0;
      r_hit_pend  <= 1'b0;
      r_data      <= OPEN_BUS_BYTE;
      r_valid     <= 1'b0;
    end else begin
      r_hit_pend <= w_hit;
      r_valid    <= r_hit_pend || i_done;
      if (i_done) begin
        r_data <= i_done_data;
      end
      // A new request in the completion cycle wins over the clear.
      if (i_req && !w_hit) begin
        r_pending <= 1'b1;
        r_addr    <= i_addr;
      end else if (i_done) begin
        r_pending <= 1'b0;
      end
      // Aborted reads never populate the hit register.
      if (i_done && i_done_ok) begin
        r_hit_valid <= 1'b1;
        r_hit_addr  <= i_done_addr;
      end else if (i_wr_done && r_hit_valid && (i_wr_addr == r_hit_addr)) begin
        r_hit_valid <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_valid   = r_valid;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cart ROM/SDRAM byte port between the ROM loader (writes),
// MARIA DMA reads and Sally CPU reads, with CPU anti-starvation and an
// ack timeout that returns open-bus data.
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int CPU_MAX_WAIT = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  cart_mem_arbiter_if.slave bus
);

  localparam int                WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam int                TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  arb_state_t        r_state;
  port_id_t          r_owner;
  logic [WAIT_W-1:0] r_cpu_wait;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [7:0]        r_rdata;
  logic              r_rd_ok;
  logic              r_dl_ack;
  logic              r_timeout_err;

  logic              w_dma_pending;
  logic              w_cpu_pending;
  logic [ADDR_W-1:0] w_dma_addr;
  logic [ADDR_W-1:0] w_cpu_addr;
  logic [7:0]        w_dma_data;
  logic [7:0]        w_cpu_data;
  logic              w_dma_valid;
  logic              w_cpu_valid;
  logic              w_grant;
  port_id_t          w_winner;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_dma_done;
  logic              w_cpu_done;
  logic              w_wr_done;

  assign w_dma_done = (r_state == DONE) && (r_owner == P_DMA);
  assign w_cpu_done = (r_state == DONE) && (r_owner == P_CPU);
  assign w_wr_done  = (r_state == DONE) && (r_owner == P_DL);

  cart_mem_port #(.ADDR_W(ADDR_W)) u_dma_port (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .i_req       (bus.dma_req),
    .i_addr      (bus.dma_addr),
    .i_done      (w_dma_done),
    .i_done_ok   (r_rd_ok),
    .i_done_addr (r_mem_addr),
    .i_done_data (r_rdata),
    .i_wr_done   (w_wr_done),
    .i_wr_addr   (r_mem_addr),
    .o_pending   (w_dma_pending),
    .o_addr      (w_dma_addr),
    .o_data      (w_dma_data),
    .o_valid     (w_dma_valid)
  );

  cart_mem_port #(.ADDR_W(ADDR_W)) u_cpu_port (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .i_req       (bus.cpu_req),
    .i_addr      (bus.cpu_addr),
    .i_done      (w_cpu_done),
    .i_done_ok   (r_rd_ok),
    .i_done_addr (r_mem_addr),
    .i_done_data (r_rdata),
    .i_wr_done   (w_wr_done),
    .i_wr_addr   (r_mem_addr),
    .o_pending   (w_cpu_pending),
    .o_addr      (w_cpu_addr),
    .o_data      (w_cpu_data),
    .o_valid     (w_cpu_valid)
  );

  // Priority pick: loader, then a starved CPU, then DMA, then CPU.
  always_comb begin
    w_grant  = 1'b1;
    w_winner = P_DL;
    if (bus.dl_req) begin
      w_winner = P_DL;
    end else if (w_cpu_pending && (r_cpu_wait == WAIT_MAX)) begin
      w_winner = P_CPU;
    end else if (w_dma_pending) begin
      w_winner = P_DMA;
    end else if (w_cpu_pending) begin
      w_winner = P_CPU;
    end else begin
      w_grant  = 1'b0;
      w_winner = P_DL;
    end
  end

  // Address of the selected requester.
  always_comb begin
    case (w_winner)
      P_DL:    w_win_addr = bus.dl_addr;
      P_DMA:   w_win_addr = w_dma_addr;
      P_CPU:   w_win_addr = w_cpu_addr;
      default: w_win_addr = '0;
    endcase
  end

  // Transaction sequencer: grant, hold the SDRAM request, complete or abort.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner       <= P_DL;
      r_cpu_wait    <= '0;
      r_tmo_cnt     <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= 8'h00;
      r_rdata       <= OPEN_BUS_BYTE;
      r_rd_ok       <= 1'b0;
      r_dl_ack      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dl_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state     <= ISSUE;
            r_owner     <= w_winner;
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_winner == P_DL);
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= (w_winner == P_DL) ? bus.dl_data : 8'h00;
            if (w_winner == P_CPU) begin
              r_cpu_wait <= '0;
            end else if ((w_winner == P_DMA) && w_cpu_pending && (r_cpu_wait != WAIT_MAX)) begin
              r_cpu_wait <= r_cpu_wait + WAIT_W'(1);
            end
          end
        end
        ISSUE: begin
          r_state   <= WAIT_ACK;
          r_tmo_cnt <= '0;
        end
        WAIT_ACK: begin
          if (bus.mem_ack) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rdata   <= bus.mem_rdata;
            r_rd_ok   <= 1'b1;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state       <= DONE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_rdata       <= OPEN_BUS_BYTE;
            r_rd_ok       <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_dl_ack <= (r_owner == P_DL);
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dl_ack      = r_dl_ack;
  assign bus.dma_data    = w_dma_data;
  assign bus.dma_valid   = w_dma_valid;
  assign bus.cpu_data    = w_cpu_data;
  assign bus.cpu_valid   = w_cpu_valid;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with a behavioural SDRAM model.
module tb_cart_mem_arbiter;

  localparam int ADDR_W = 25;

  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // SDRAM model controls and transaction log.
  int                mem_lat    = 1;
  bit                mem_hold   = 1'b0;
  int                req_cycles = 0;
  logic [ADDR_W-1:0] tx_addr [$];
  logic              tx_we   [$];
  logic [7:0]        tx_wd   [$];
  logic [7:0]        mem_bytes [int];

  cart_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  cart_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .CPU_MAX_WAIT (4),
    .ACK_TIMEOUT  (64)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: ack mem_lat cycles after mem_req is first seen high.
  initial begin : mem_model
    int cnt;
    int a;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    mem_bytes[32'h0000C000] = 8'hA5;
    forever begin
      @(posedge clk_sys);
      #1;
      if (bus.mem_req) req_cycles++;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_req && !mem_hold) begin
        if (cnt >= mem_lat) begin
          a = int'(bus.mem_addr);
          tx_addr.push_back(bus.mem_addr);
          tx_we.push_back(bus.mem_we);
          tx_wd.push_back(bus.mem_wdata);
          if (bus.mem_we) mem_bytes[a] = bus.mem_wdata;
          else bus.mem_rdata = mem_bytes.exists(a) ? mem_bytes[a] : (8'h5A ^ a[7:0]);
          bus.mem_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse cpu_req; lat = cycles from the capture edge to cpu_valid (-1 if none).
  task automatic cpu_read(input logic [ADDR_W-1:0] addr, output int lat, output logic [7:0] data);
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    lat  = -1;
    data = 8'h00;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (bus.cpu_valid === 1'b1) begin
        lat  = n;
        data = bus.cpu_data;
        break;
      end
    end
  endtask

  // Wait for mem_ack, then step into the DONE cycle that follows it.
  task automatic wait_ack(input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_sys);
      if (bus.mem_ack === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
    @(posedge clk_sys);
    #1;
  endtask

  initial begin : stim
    int         lat;
    logic [7:0] d;
    int         base_req;
    int         base_tx;
    bit         seen_a;
    bit         seen_b;
    logic [7:0] d_a;
    logic [7:0] d_b;

    reset        = 1'b1;
    bus.dl_req   = 1'b0;
    bus.dl_addr  = '0;
    bus.dl_data  = 8'h00;
    bus.dma_req  = 1'b0;
    bus.dma_addr = '0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    tick();
    tick();

    // Reset values
    check("rst_mem_req",   32'(bus.mem_req),     32'd0);
    check("rst_mem_we",    32'(bus.mem_we),      32'd0);
    check("rst_dma_data",  32'(bus.dma_data),    32'hFF);
    check("rst_cpu_data",  32'(bus.cpu_data),    32'hFF);
    check("rst_valids",    32'({bus.dma_valid, bus.cpu_valid, bus.dl_ack}), 32'd0);
    check("rst_tmo_err",   32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    tick();

    // CPU miss, memory acks 2 cycles after mem_req
    mem_lat  = 2;
    base_req = req_cycles;
    cpu_read(25'h0C000, lat, d);
    check("miss_latency",  32'(lat), 32'd5);
    check("miss_data",     32'(d),   32'hA5);
    check("miss_req_len",  32'(req_cycles - base_req), 32'd3);
    tick();
    check("valid_is_pulse", 32'(bus.cpu_valid), 32'd0);
    check("data_held",      32'(bus.cpu_data),  32'hA5);

    // Repeat read hits
    base_req = req_cycles;
    cpu_read(25'h0C000, lat, d);
    check("hit_latency",  32'(lat), 32'd1);
    check("hit_data",     32'(d),   32'hA5);
    check("hit_no_mem",   32'(req_cycles - base_req), 32'd0);

    // Loader write to the hit address invalidates the CPU hit entry
    base_tx     = tx_addr.size();
    bus.dl_addr = 25'h0C000;
    bus.dl_data = 8'h3C;
    bus.dl_req  = 1'b1;
    seen_a      = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (bus.dl_ack === 1'b1) begin
        seen_a = 1'b1;
        break;
      end
    end
    bus.dl_req = 1'b0;
    check("wr_dl_ack", 32'(seen_a), 32'd1);
    tick();
    check("wr_ack_pulse", 32'(bus.dl_ack), 32'd0);
    check("wr_tx_count", 32'(tx_addr.size() - base_tx), 32'd1);
    if (tx_addr.size() > base_tx) begin
      check("wr_tx_we",    32'(tx_we[base_tx]),   32'd1);
      check("wr_tx_addr",  32'(tx_addr[base_tx]), 32'h0C000);
      check("wr_tx_wdata", 32'(tx_wd[base_tx]),   32'h3C);
    end
    base_req = req_cycles;
    cpu_read(25'h0C000, lat, d);
    check("coh_latency", 32'(lat), 32'd5);
    check("coh_data",    32'(d),   32'h3C);
    check("coh_req_len", 32'(req_cycles - base_req), 32'd3);

    // Simultaneous DMA and CPU misses: DMA served first
    mem_lat      = 1;
    base_tx      = tx_addr.size();
    bus.dma_addr = 25'h00101;
    bus.cpu_addr = 25'h00203;
    bus.dma_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    tick();
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    d_a    = 8'h00;
    d_b    = 8'h00;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (bus.dma_valid === 1'b1) begin
        seen_a = 1'b1;
        d_a    = bus.dma_data;
      end
      if (bus.cpu_valid === 1'b1) begin
        seen_b = 1'b1;
        d_b    = bus.cpu_data;
      end
    end
    check("both_dma_valid", 32'(seen_a), 32'd1);
    check("both_cpu_valid", 32'(seen_b), 32'd1);
    check("both_dma_data",  32'(d_a),    32'h5B);
    check("both_cpu_data",  32'(d_b),    32'h59);
    check("both_tx_count",  32'(tx_addr.size() - base_tx), 32'd2);
    if (tx_addr.size() >= base_tx + 2) begin
      check("both_first_dma",  32'(tx_addr[base_tx]),     32'h00101);
      check("both_second_cpu", 32'(tx_addr[base_tx + 1]), 32'h00203);
    end

    // CPU pending against back-to-back DMA: CPU wins after the 4th DMA
    base_tx      = tx_addr.size();
    bus.cpu_addr = 25'h00300;
    bus.dma_addr = 25'h00400;
    bus.cpu_req  = 1'b1;
    bus.dma_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("starve_ack_seen");
      bus.dma_addr = 25'(32'h401 + k);
      bus.dma_req  = 1'b1;
      tick();
      bus.dma_req = 1'b0;
    end
    repeat (40) tick();
    check("starve_tx_count", 32'(tx_addr.size() - base_tx), 32'd6);
    if (tx_addr.size() >= base_tx + 6) begin
      check("starve_4th_dma", 32'(tx_addr[base_tx + 3]), 32'h00403);
      check("starve_cpu",     32'(tx_addr[base_tx + 4]), 32'h00300);
      check("starve_5th_dma", 32'(tx_addr[base_tx + 5]), 32'h00404);
    end

    // Ack withheld: abort with open-bus data and sticky error
    mem_hold = 1'b1;
    cpu_read(25'h00500, lat, d);
    check("tmo_latency_range", 32'((lat >= 64) && (lat <= 70)), 32'd1);
    check("tmo_data",          32'(d), 32'hFF);
    check("tmo_err_set",       32'(bus.timeout_err), 32'd1);
    mem_hold = 1'b0;
    mem_lat  = 2;
    cpu_read(25'h00500, lat, d);
    check("tmo_no_hit_latency", 32'(lat), 32'd5);
    check("tmo_no_hit_data",    32'(d),   32'h5A);
    check("tmo_err_sticky",     32'(bus.timeout_err), 32'd1);

    // Reset during WAIT_ACK
    mem_hold     = 1'b1;
    bus.cpu_addr = 25'h00600;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    tick();
    tick();
    check("rstmid_req_high", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_req_drop", 32'(bus.mem_req),     32'd0);
    check("rstmid_err_clr",  32'(bus.timeout_err), 32'd0);
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.cpu_valid !== 1'b0) seen_a = 1'b1;
      if (bus.mem_req !== 1'b0) seen_b = 1'b1;
    end
    check("rstmid_no_valid", 32'(seen_a), 32'd0);
    check("rstmid_req_idle", 32'(seen_b), 32'd0);
    mem_hold = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
